// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// rtl/pipe_hazard_cmp.sv - combinational load-use hazard compare for the IF/ID instruction
module pipe_hazard_cmp (
  input  logic [15:0] instr,
  input  logic        uses_rs,
  input  logic        uses_rt,
  input  logic        mem_read,
  input  logic [2:0]  wr_reg,
  output logic        load_use
);
  import pipe_ctrl_pkg::*;

  logic [2:0] rs;
  logic [2:0] rt;
  logic       unused_instr_bits;

  assign rs = instr[RS_HI:RS_LO];
  assign rt = instr[RT_HI:RT_LO];
  assign unused_instr_bits = ^{instr[15:11], instr[4:0]};

  assign load_use = mem_read && ((uses_rs && (rs == wr_reg)) || (uses_rt && (rt == wr_reg)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush controller driving PC and pipeline register enables/flushes
// Optional PIPE_CTRL_PERF_EN adds saturating stall and flush cycle counters.
module pipe_ctrl #(
  parameter logic [15:0] NOP_INSTR = pipe_ctrl_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ifid_instr,
  input  logic        ifid_uses_rs,
  input  logic        ifid_uses_rt,
  input  logic        idex_mem_read,
  input  logic [2:0]  idex_wr_reg,
  input  logic        ex_redirect,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
`ifdef PIPE_CTRL_PERF_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  output logic        halted
);
  import pipe_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   drop_next_q, drop_next_d;
  logic   halted_q, halted_d;
  logic   load_use;
  logic   halt_now;
  logic   unused_nop;

  assign unused_nop = ^NOP_INSTR;

  pipe_hazard_cmp u_hazard (
    .instr    (ifid_instr),
    .uses_rs  (ifid_uses_rs),
    .uses_rt  (ifid_uses_rt),
    .mem_read (idex_mem_read),
    .wr_reg   (idex_wr_reg),
    .load_use (load_use)
  );

  assign halt_now = (state_q == HALT) || wb_halt;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    state_d     = RUN;
    drop_next_d = drop_next_q;
    halted_d    = halted_q;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      drop_next_d = 1'b0;
      halted_d    = 1'b0;
    end else if (halt_now) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      state_d  = HALT;
      halted_d = 1'b1;
    end else if (dmem_stall) begin
      // Everything upstream of MEM/WB freezes; pending redirect/load-use re-evaluate later.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_d     = DWAIT;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      drop_next_d = imem_stall;
      state_d     = imem_stall ? IWAIT : RUN;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (imem_stall) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      state_d    = IWAIT;
    end else if (drop_next_q) begin
      // The fetch just completing was issued down the wrong path.
      ifid_flush  = 1'b1;
      drop_next_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drop_next_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_next_q <= drop_next_d;
      halted_q    <= halted_d;
    end
  end

  assign halted = halted_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!halt_now) begin
      if (!pc_en && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if ((ifid_flush || idex_flush) && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table, directed and randomized checks of pipe_ctrl against a priority-rule model
module tb_pipe_ctrl;

  typedef struct packed {
    logic        rst;
    logic [15:0] instr;
    logic        uses_rs;
    logic        uses_rt;
    logic        mem_read;
    logic [2:0]  wr_reg;
    logic        redirect;
    logic        imem;
    logic        dmem;
    logic        halt;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ifid_instr = '0;
  logic        ifid_uses_rs = 1'b0, ifid_uses_rt = 1'b0, idex_mem_read = 1'b0;
  logic [2:0]  idex_wr_reg = '0;
  logic        ex_redirect = 1'b0, imem_stall = 1'b0, dmem_stall = 1'b0, wb_halt = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic m_halt = 1'b0;
  logic m_drop = 1'b0;
  vec_t vecs[11];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ifid_instr    (ifid_instr),
    .ifid_uses_rs  (ifid_uses_rs),
    .ifid_uses_rt  (ifid_uses_rt),
    .idex_mem_read (idex_mem_read),
    .idex_wr_reg   (idex_wr_reg),
    .ex_redirect   (ex_redirect),
    .imem_stall    (imem_stall),
    .dmem_stall    (dmem_stall),
    .wb_halt       (wb_halt),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .memwb_flush   (memwb_flush),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .halted        (halted)
  );

  function automatic in_t mk(logic r, logic [15:0] i, logic urs, logic urt, logic mr,
                             logic [2:0] wr, logic rd, logic im, logic dm, logic hl);
    in_t v;
    v = '{rst: r, instr: i, uses_rs: urs, uses_rt: urt, mem_read: mr, wr_reg: wr,
          redirect: rd, imem: im, dmem: dm, halt: hl};
    return v;
  endfunction

  // Expected {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}.
  function automatic logic [6:0] model_out(in_t v, logic h, logic d);
    logic lu;
    lu = v.mem_read && ((v.uses_rs && v.instr[10:8] == v.wr_reg) ||
                        (v.uses_rt && v.instr[7:5] == v.wr_reg));
    if (v.rst)           return 7'b0000_111;
    if (h || v.halt)     return 7'b0000_000;
    if (v.dmem)          return 7'b0000_001;
    if (v.redirect)      return 7'b1111_110;
    if (lu)              return 7'b0011_010;
    if (v.imem)          return 7'b0111_100;
    if (d)               return 7'b1111_100;
    return 7'b1111_000;
  endfunction

  task automatic model_step(in_t v);
    logic lu;
    lu = v.mem_read && ((v.uses_rs && v.instr[10:8] == v.wr_reg) ||
                        (v.uses_rt && v.instr[7:5] == v.wr_reg));
    if (v.rst) begin
      m_halt = 1'b0;
      m_drop = 1'b0;
    end else if (m_halt || v.halt) begin
      m_halt = 1'b1;
    end else if (v.dmem) begin
      m_drop = m_drop;
    end else if (v.redirect) begin
      m_drop = v.imem;
    end else if (!lu && !v.imem) begin
      m_drop = 1'b0;
    end
  endtask

  task automatic drive(in_t v);
    rst           = v.rst;
    ifid_instr    = v.instr;
    ifid_uses_rs  = v.uses_rs;
    ifid_uses_rt  = v.uses_rt;
    idex_mem_read = v.mem_read;
    idex_wr_reg   = v.wr_reg;
    ex_redirect   = v.redirect;
    imem_stall    = v.imem;
    dmem_stall    = v.dmem;
    wb_halt       = v.halt;
  endtask

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(in_t v, logic [6:0] exp, string name);
    @(negedge clk);
    drive(v);
    #2;
    check(name, {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}, {9'd0, exp});
    check({name, "_halted"}, {15'd0, halted}, {15'd0, m_halt});
    model_step(v);
  endtask

  initial begin
    in_t idle, rstv, v;
    idle = mk(0, 16'h0000, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    rstv = mk(1, 16'h0000, 0, 0, 0, 3'd0, 0, 0, 0, 0);

    vecs[0]  = '{mk(0, 16'hDB40, 0, 0, 0, 3'd3, 0, 0, 0, 0), 7'b1111_000, "idle"};
    vecs[1]  = '{mk(0, 16'hDB40, 1, 0, 1, 3'd3, 0, 0, 0, 0), 7'b0011_010, "lu_rs"};
    vecs[2]  = '{mk(0, 16'hDB40, 0, 1, 1, 3'd2, 0, 0, 0, 0), 7'b0011_010, "lu_rt"};
    vecs[3]  = '{mk(0, 16'hDB40, 1, 0, 0, 3'd3, 0, 0, 0, 0), 7'b1111_000, "no_load"};
    vecs[4]  = '{mk(0, 16'hDB40, 0, 0, 1, 3'd3, 0, 0, 0, 0), 7'b1111_000, "no_use"};
    vecs[5]  = '{mk(0, 16'hDB40, 1, 0, 1, 3'd3, 1, 0, 0, 0), 7'b1111_110, "redir_over_lu"};
    vecs[6]  = '{mk(0, 16'h0000, 0, 0, 0, 3'd0, 0, 1, 0, 0), 7'b0111_100, "imem"};
    vecs[7]  = '{mk(0, 16'h0000, 0, 0, 0, 3'd0, 1, 0, 1, 0), 7'b0000_001, "dmem_over_redir"};
    vecs[8]  = '{mk(0, 16'h0000, 0, 0, 0, 3'd0, 0, 0, 1, 1), 7'b0000_000, "halt_over_dmem"};
    vecs[9]  = '{mk(1, 16'h0000, 0, 0, 0, 3'd0, 1, 0, 1, 1), 7'b0000_111, "rst_over_all"};
    vecs[10] = '{mk(0, 16'hDB40, 1, 0, 1, 3'd3, 0, 1, 0, 0), 7'b0011_010, "lu_over_imem"};

    drive(rstv);
    step(rstv, 7'b0000_111, "reset0");
    step(rstv, 7'b0000_111, "reset1");

    for (int i = 0; i < 11; i++) begin
      step(rstv, 7'b0000_111, "vec_rst");
      step(vecs[i].in, vecs[i].exp, vecs[i].name);
    end

    // Load-use costs exactly one bubble.
    step(rstv, 7'b0000_111, "seq_rst");
    step(vecs[1].in, 7'b0011_010, "lu_cycle");
    step(mk(0, 16'hDB40, 1, 0, 0, 3'd0, 0, 0, 0, 0), 7'b1111_000, "lu_after");

    // Redirect during an outstanding fetch: the stale fetch is dropped on completion.
    step(mk(0, 16'h0000, 0, 0, 0, 3'd0, 1, 1, 0, 0), 7'b1111_110, "rd_imem");
    for (int i = 0; i < 3; i++) step(mk(0, 16'h0, 0, 0, 0, 3'd0, 0, 1, 0, 0), 7'b0111_100, "rd_imem_hold");
    step(idle, 7'b1111_100, "rd_drop");
    step(idle, 7'b1111_000, "rd_after_drop");

    // Data stall holds off a redirect until it clears.
    for (int i = 0; i < 5; i++) step(mk(0, 16'h0, 0, 0, 0, 3'd0, 1, 0, 1, 0), 7'b0000_001, "dwait");
    step(mk(0, 16'h0, 0, 0, 0, 3'd0, 1, 0, 0, 0), 7'b1111_110, "dwait_redir");

    // Halt is sticky until reset.
    step(mk(0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0, 1), 7'b0000_000, "halt_pulse");
    step(vecs[0].in, 7'b0000_000, "halted0");
    step(vecs[6].in, 7'b0000_000, "halted1");
    check("halted_high", {15'd0, halted}, 16'd1);
    step(rstv, 7'b0000_111, "halt_rst");
    step(idle, 7'b1111_000, "after_halt_rst");
    check("halted_low", {15'd0, halted}, 16'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      v = mk($urandom_range(0, 29) == 0, ins, 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 1) ? ins[10:8] : 3'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0);
      step(v, model_out(v, m_halt, m_drop), "rand");
    end

`ifdef PIPE_CTRL_PERF_EN
    step(rstv, 7'b0000_111, "perf_rst");
    for (int i = 0; i < 3; i++) step(vecs[6].in, 7'b0111_100, "perf_imem");
    @(negedge clk);
    #2;
    check("perf_stall3", perf_stall_cnt, 16'd3);
    check("perf_flush3", perf_flush_cnt, 16'd3);
    drive(vecs[6].in);
    for (int i = 0; i < 65535; i++) @(negedge clk);
    #2;
    check("perf_stall_sat", perf_stall_cnt, 16'hFFFF);
    check("perf_flush_sat", perf_flush_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
